// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port round-robin arbiter in front of the DDR3 master port
// One transaction in flight; per-transaction watchdog aborts a bridge that never completes.
module sdram_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] req0_address,
   input  logic                  req0_rd_en,
   input  logic                  req0_wr_en,
   input  logic [DATA_WIDTH-1:0] req0_write_data,
   output logic [DATA_WIDTH-1:0] req0_read_data,
   output logic                  req0_read_complete,
   output logic                  req0_write_complete,
   input  logic [ADDR_WIDTH-1:0] req1_address,
   input  logic                  req1_rd_en,
   input  logic                  req1_wr_en,
   input  logic [DATA_WIDTH-1:0] req1_write_data,
   output logic [DATA_WIDTH-1:0] req1_read_data,
   output logic                  req1_read_complete,
   output logic                  req1_write_complete,
   output logic [ADDR_WIDTH-1:0] sdram_address,
   output logic                  rd_en,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] write_data_input,
   input  logic [DATA_WIDTH-1:0] read_data,
   input  logic                  write_complete,
   input  logic                  read_complete,
   output logic [1:0]            grant,
   output logic                  timeout_error
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic [1:0]            grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic                  rc0_q, rc0_d, wc0_q, wc0_d;
   logic                  rc1_q, rc1_d, wc1_q, wc1_d;
   logic                  timeout_error_q, timeout_error_d;

   logic act0, act1, pick1, match;

   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      grant_d         = grant_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      rd_en_d         = rd_en_q;
      wr_en_d         = wr_en_q;
      cnt_d           = cnt_q;
      rdata0_d        = rdata0_q;
      rdata1_d        = rdata1_q;
      rc0_d           = 1'b0;
      wc0_d           = 1'b0;
      rc1_d           = 1'b0;
      wc1_d           = 1'b0;
      timeout_error_d = timeout_error_q;
      act0            = req0_rd_en | req0_wr_en;
      act1            = req1_rd_en | req1_wr_en;
      pick1           = act1 & (~act0 | ~last_grant_q);
      match           = wr_en_q ? write_complete : read_complete;

      case (state_q)
         IDLE: begin
            if (act0 | act1) begin
               last_grant_d = pick1;
               grant_d      = pick1 ? 2'b10 : 2'b01;
               addr_d       = pick1 ? req1_address : req0_address;
               wdata_d      = pick1 ? req1_write_data : req0_write_data;
               // A requester raising both levels gets a write.
               wr_en_d      = pick1 ? req1_wr_en : req0_wr_en;
               rd_en_d      = ~wr_en_d;
               cnt_d        = '0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (match || cnt_q == CNT_LAST) begin
               rd_en_d = 1'b0;
               wr_en_d = 1'b0;
               grant_d = 2'b00;
               state_d = RELEASE;
               if (!match) timeout_error_d = 1'b1;
               // Aborted reads still pulse complete but leave the data register alone.
               if (last_grant_q) begin
                  rc1_d = rd_en_q;
                  wc1_d = wr_en_q;
                  if (match && rd_en_q) rdata1_d = read_data;
               end else begin
                  rc0_d = rd_en_q;
                  wc0_d = wr_en_q;
                  if (match && rd_en_q) rdata0_d = read_data;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         last_grant_q    <= 1'b1;
         grant_q         <= 2'b00;
         addr_q          <= '0;
         wdata_q         <= '0;
         rd_en_q         <= 1'b0;
         wr_en_q         <= 1'b0;
         cnt_q           <= '0;
         rdata0_q        <= '0;
         rdata1_q        <= '0;
         rc0_q           <= 1'b0;
         wc0_q           <= 1'b0;
         rc1_q           <= 1'b0;
         wc1_q           <= 1'b0;
         timeout_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         grant_q         <= grant_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         rd_en_q         <= rd_en_d;
         wr_en_q         <= wr_en_d;
         cnt_q           <= cnt_d;
         rdata0_q        <= rdata0_d;
         rdata1_q        <= rdata1_d;
         rc0_q           <= rc0_d;
         wc0_q           <= wc0_d;
         rc1_q           <= rc1_d;
         wc1_q           <= wc1_d;
         timeout_error_q <= timeout_error_d;
      end
   end

   assign sdram_address       = addr_q;
   assign write_data_input    = wdata_q;
   assign rd_en               = rd_en_q;
   assign wr_en               = wr_en_q;
   assign grant               = grant_q;
   assign timeout_error       = timeout_error_q;
   assign req0_read_data      = rdata0_q;
   assign req1_read_data      = rdata1_q;
   assign req0_read_complete  = rc0_q;
   assign req0_write_complete = wc0_q;
   assign req1_read_complete  = rc1_q;
   assign req1_write_complete = wc1_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed bench with a transaction-level reference model
module tb_sdram_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic [AW-1:0] req_addr[2];
   logic          req_rd[2];
   logic          req_wr[2];
   logic [DW-1:0] req_wd[2];
   logic [DW-1:0] req0_read_data, req1_read_data;
   logic          req0_read_complete, req0_write_complete;
   logic          req1_read_complete, req1_write_complete;
   logic [AW-1:0] sdram_address;
   logic          rd_en, wr_en;
   logic [DW-1:0] write_data_input;
   logic [DW-1:0] read_data = 32'h5A5A_5A5A;
   logic          write_complete = 1'b0;
   logic          read_complete = 1'b0;
   logic [1:0]    grant;
   logic          timeout_error;

   sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset),
      .req0_address(req_addr[0]), .req0_rd_en(req_rd[0]), .req0_wr_en(req_wr[0]),
      .req0_write_data(req_wd[0]), .req0_read_data(req0_read_data),
      .req0_read_complete(req0_read_complete), .req0_write_complete(req0_write_complete),
      .req1_address(req_addr[1]), .req1_rd_en(req_rd[1]), .req1_wr_en(req_wr[1]),
      .req1_write_data(req_wd[1]), .req1_read_data(req1_read_data),
      .req1_read_complete(req1_read_complete), .req1_write_complete(req1_write_complete),
      .sdram_address(sdram_address), .rd_en(rd_en), .wr_en(wr_en),
      .write_data_input(write_data_input), .read_data(read_data),
      .write_complete(write_complete), .read_complete(read_complete),
      .grant(grant), .timeout_error(timeout_error)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: one transaction record plus a cool-down slot and a grant log.
   logic          m_busy, m_wr, m_who, m_cool, m_last, m_err;
   int            m_age;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [DW-1:0] m_rdata[2];
   logic          m_prd[2], m_pwr[2];
   int            m_log[$];
   logic          m_act0, m_act1, m_pick;

   assign m_act0 = req_rd[0] | req_wr[0];
   assign m_act1 = req_rd[1] | req_wr[1];
   assign m_pick = (m_act1 && !m_act0) || (m_act0 && m_act1 && !m_last);

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0; m_wr <= 1'b0; m_who <= 1'b0; m_cool <= 1'b0;
         m_last <= 1'b1; m_err <= 1'b0; m_age <= 0;
         m_addr <= '0; m_data <= '0;
         m_rdata[0] <= '0; m_rdata[1] <= '0;
         m_prd[0] <= 1'b0; m_prd[1] <= 1'b0; m_pwr[0] <= 1'b0; m_pwr[1] <= 1'b0;
      end else begin
         m_prd[0] <= 1'b0; m_prd[1] <= 1'b0; m_pwr[0] <= 1'b0; m_pwr[1] <= 1'b0;
         if (m_busy) begin
            if ((m_wr ? write_complete : read_complete) == 1'b1) begin
               m_busy <= 1'b0; m_cool <= 1'b1;
               if (m_wr) m_pwr[m_who] <= 1'b1;
               else begin
                  m_prd[m_who]   <= 1'b1;
                  m_rdata[m_who] <= read_data;
               end
            end else if (m_age == T - 1) begin
               m_busy <= 1'b0; m_cool <= 1'b1; m_err <= 1'b1;
               if (m_wr) m_pwr[m_who] <= 1'b1;
               else m_prd[m_who] <= 1'b1;
            end else begin
               m_age <= m_age + 1;
            end
         end else if (m_cool) begin
            m_cool <= 1'b0;
         end else if (m_act0 || m_act1) begin
            m_busy <= 1'b1; m_age <= 0;
            m_who  <= m_pick; m_last <= m_pick;
            m_wr   <= m_pick ? req_wr[1] : req_wr[0];
            m_addr <= m_pick ? req_addr[1] : req_addr[0];
            m_data <= m_pick ? req_wd[1] : req_wd[0];
            m_log.push_back(m_pick ? 1 : 0);
         end
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clock);
      if (!reset) begin
         chk("rd_en", 64'(rd_en), 64'(m_busy && !m_wr));
         chk("wr_en", 64'(wr_en), 64'(m_busy && m_wr));
         chk("grant", 64'(grant), m_busy ? (m_who ? 64'd2 : 64'd1) : 64'd0);
         chk("req0_read_complete", 64'(req0_read_complete), 64'(m_prd[0]));
         chk("req0_write_complete", 64'(req0_write_complete), 64'(m_pwr[0]));
         chk("req1_read_complete", 64'(req1_read_complete), 64'(m_prd[1]));
         chk("req1_write_complete", 64'(req1_write_complete), 64'(m_pwr[1]));
         chk("req0_read_data", 64'(req0_read_data), 64'(m_rdata[0]));
         chk("req1_read_data", 64'(req1_read_data), 64'(m_rdata[1]));
         chk("timeout_error", 64'(timeout_error), 64'(m_err));
         if (m_busy) begin
            chk("sdram_address", 64'(sdram_address), 64'(m_addr));
            if (m_wr) chk("write_data_input", 64'(write_data_input), 64'(m_data));
         end
      end
   end

   // Bridge: completes after br_lat request cycles (mode 0), never (mode 1),
   // or sends a stray write_complete at cycle 2 before the read completes (mode 2).
   int            br_mode = 0;
   int            br_lat = 5;
   logic [DW-1:0] br_rdata = '0;

   initial begin
      int   br_cnt;
      logic br_done;
      br_cnt  = 0;
      br_done = 1'b0;
      forever begin
         @(negedge clock);
         read_complete  = 1'b0;
         write_complete = 1'b0;
         read_data      = 32'h5A5A_5A5A;
         if (rd_en || wr_en) begin
            if (!br_done) begin
               br_cnt++;
               if (br_mode == 2 && br_cnt == 2) write_complete = 1'b1;
               if (br_mode != 1 && br_cnt == br_lat) begin
                  if (wr_en) write_complete = 1'b1;
                  else read_complete = 1'b1;
                  read_data = br_rdata;
                  br_done   = 1'b1;
               end
            end
         end else begin
            br_cnt  = 0;
            br_done = 1'b0;
         end
      end
   end

   // Requesters: hold the level for rq_left transactions, stepping address/data after each pulse.
   int   rq_left[2];
   int   pr_cnt[2];
   int   pw_cnt[2];
   logic pr[2], pw[2];
   assign pr[0] = req0_read_complete;
   assign pr[1] = req1_read_complete;
   assign pw[0] = req0_write_complete;
   assign pw[1] = req1_write_complete;

   initial forever begin
      @(negedge clock);
      for (int n = 0; n < 2; n++) begin
         if (pr[n]) pr_cnt[n]++;
         if (pw[n]) pw_cnt[n]++;
         if ((pr[n] || pw[n]) && rq_left[n] > 0) begin
            rq_left[n]--;
            if (rq_left[n] == 0) begin
               req_rd[n] = 1'b0;
               req_wr[n] = 1'b0;
            end else begin
               req_addr[n] = req_addr[n] + 32'd4;
               req_wd[n]   = req_wd[n] + 32'd1;
            end
         end
      end
   end

   task automatic start(input int n, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input int cnt);
      req_addr[n] = a;
      req_wd[n]   = d;
      req_rd[n]   = rd;
      req_wr[n]   = wr;
      rq_left[n]  = cnt;
   endtask

   task automatic wait_idle(output int hi);
      bit done;
      hi   = 0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clock);
         #1;
         if (rd_en || wr_en) hi++;
         if (rq_left[0] == 0 && rq_left[1] == 0) done = 1'b1;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_bound: requests still pending after 200 cycles");
         for (int n = 0; n < 2; n++) begin
            req_rd[n] = 1'b0; req_wr[n] = 1'b0; rq_left[n] = 0;
         end
      end
      repeat (2) @(negedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int hi, pulse_at, p0, w0;
      for (int n = 0; n < 2; n++) begin
         req_addr[n] = '0; req_wd[n] = '0; req_rd[n] = 1'b0; req_wr[n] = 1'b0;
         rq_left[n] = 0; pr_cnt[n] = 0; pw_cnt[n] = 0;
      end
      repeat (3) @(negedge clock);
      #1;
      chk("reset_rd_en", 64'(rd_en), 64'd0);
      chk("reset_grant", 64'(grant), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      #1;
      chk("post_reset_timeout_error", 64'(timeout_error), 64'd0);
      chk("post_reset_read_data", 64'(req0_read_data), 64'd0);

      // Single read, bridge completes on its 5th request cycle.
      br_mode = 0; br_lat = 5; br_rdata = 32'hDEAD_BEEF;
      start(0, 1'b1, 1'b0, 32'h0000_0100, '0, 1);
      pulse_at = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clock);
         #1;
         if (i == 1) begin
            chk("t1_rd_en_next_cycle", 64'(rd_en), 64'd1);
            chk("t1_grant_01", 64'(grant), 64'd1);
            chk("t1_address", 64'(sdram_address), 64'h100);
         end
         if (req0_read_complete && pulse_at < 0) pulse_at = i;
      end
      chk("t1_complete_latency", 64'(pulse_at), 64'd6);
      chk("t1_read_data", 64'(req0_read_data), 64'hDEAD_BEEF);
      chk("t1_grant_00", 64'(grant), 64'd0);

      // Simultaneous write (req0) and read (req1) right after reset.
      do_reset();
      m_log.delete();
      br_rdata = 32'hCAFE_0001;
      start(0, 1'b0, 1'b1, 32'h0000_2000, 32'h1111_2222, 1);
      start(1, 1'b1, 1'b0, 32'h0000_3000, '0, 1);
      wait_idle(hi);
      chk("t2_log_size", 64'(m_log.size()), 64'd2);
      if (m_log.size() == 2) begin
         chk("t2_first_owner", 64'(m_log[0]), 64'd0);
         chk("t2_second_owner", 64'(m_log[1]), 64'd1);
      end
      chk("t2_req1_data", 64'(req1_read_data), 64'hCAFE_0001);
      chk("t2_req0_data_untouched", 64'(req0_read_data), 64'd0);

      // Both held for three transactions each: strict alternation.
      m_log.delete();
      br_rdata = 32'h0BAD_F00D;
      start(0, 1'b1, 1'b0, 32'h0000_4000, '0, 3);
      start(1, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_00AA, 3);
      wait_idle(hi);
      chk("t3_log_size", 64'(m_log.size()), 64'd6);
      if (m_log.size() == 6) begin
         chk("t3_owner0", 64'(m_log[0]), 64'd0);
         chk("t3_owner1", 64'(m_log[1]), 64'd1);
         chk("t3_owner2", 64'(m_log[2]), 64'd0);
         chk("t3_owner3", 64'(m_log[3]), 64'd1);
         chk("t3_owner4", 64'(m_log[4]), 64'd0);
         chk("t3_owner5", 64'(m_log[5]), 64'd1);
      end
      chk("t3_req0_data", 64'(req0_read_data), 64'h0BAD_F00D);

      // Watchdog: bridge never answers req1's read.
      br_mode = 1;
      p0 = pr_cnt[1];
      start(1, 1'b1, 1'b0, 32'h0000_6000, '0, 1);
      wait_idle(hi);
      chk("t4_rd_en_high_cycles", 64'(hi), 64'd8);
      chk("t4_req1_pulse", 64'(pr_cnt[1] - p0), 64'd1);
      chk("t4_timeout_error", 64'(timeout_error), 64'd1);
      chk("t4_req1_data_kept", 64'(req1_read_data), 64'hCAFE_0001);
      br_mode = 0;
      w0 = pw_cnt[0];
      start(0, 1'b0, 1'b1, 32'h0000_7000, 32'h0000_0077, 1);
      wait_idle(hi);
      chk("t4_write_high_cycles", 64'(hi), 64'd5);
      chk("t4_write_pulse", 64'(pw_cnt[0] - w0), 64'd1);
      chk("t4_timeout_sticky", 64'(timeout_error), 64'd1);

      // Stray write_complete during a read is ignored.
      br_mode = 2; br_rdata = 32'h1234_5678;
      p0 = pr_cnt[0]; w0 = pw_cnt[0];
      start(0, 1'b1, 1'b0, 32'h0000_8000, '0, 1);
      wait_idle(hi);
      chk("t5_no_write_pulse", 64'(pw_cnt[0] - w0), 64'd0);
      chk("t5_one_read_pulse", 64'(pr_cnt[0] - p0), 64'd1);
      chk("t5_read_data", 64'(req0_read_data), 64'h1234_5678);

      // Reset in the middle of ISSUE; the held request is granted again afterwards.
      br_mode = 1; br_rdata = 32'h0F0F_0F0F;
      p0 = pr_cnt[0];
      start(0, 1'b1, 1'b0, 32'h0000_9000, '0, 1);
      repeat (3) @(negedge clock);
      #1;
      chk("t6_in_issue", 64'(rd_en), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("t6_rst_rd_en", 64'(rd_en), 64'd0);
      chk("t6_rst_wr_en", 64'(wr_en), 64'd0);
      chk("t6_rst_grant", 64'(grant), 64'd0);
      chk("t6_rst_completes", 64'({req0_read_complete, req0_write_complete,
                                   req1_read_complete, req1_write_complete}), 64'd0);
      chk("t6_rst_timeout_error", 64'(timeout_error), 64'd0);
      br_mode = 0;
      repeat (2) @(negedge clock);
      m_log.delete();
      reset = 1'b0;
      wait_idle(hi);
      chk("t6_regrant_count", 64'(m_log.size()), 64'd1);
      chk("t6_one_pulse", 64'(pr_cnt[0] - p0), 64'd1);
      chk("t6_read_data", 64'(req0_read_data), 64'h0F0F_0F0F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
